// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner encodings and default widths for mem_arbiter
package mem_arb_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: picks the winner of an IDLE-cycle grant and tracks fetch starvation
//   clk, rst    : clock, asynchronous active-low reset
//   i_req       : raw fetch request (decides whether a data grant counts as starving fetch)
//   i_elig      : fetch port eligible this cycle
//   d_elig      : data port eligible this cycle
//   grant       : a grant is taken this cycle
//   fetch_wins  : fetch owns the grant when one is taken
//   starve_cnt  : consecutive data grants made while fetch was requesting
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic             i_elig,
    input  logic             d_elig,
    input  logic             grant,
    output logic             fetch_wins,
    output logic [CNT_W-1:0] starve_cnt
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_d, starve_cnt_q;

    // Data has priority unless fetch has already been passed over MAX times.
    always_comb begin
        fetch_wins   = i_elig && (!d_elig || starve_cnt_q == MAX);
        starve_cnt_d = !grant                   ? starve_cnt_q :
                       (fetch_wins || !i_req)   ? '0 :
                       (starve_cnt_q == MAX)    ? MAX : starve_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) starve_cnt_q <= '0;
        else      starve_cnt_q <= starve_cnt_d;
    end

    assign starve_cnt = starve_cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between fetch and data ports
//   clk, rst                    : clock, asynchronous active-low reset
//   i_req/i_addr                : fetch request, held until i_ready
//   i_ready/i_rdata             : fetch completion pulse and registered fetched word
//   d_req/d_we/d_addr/d_wdata   : data request (d_we all-zero = read), held until d_ready
//   d_ready/d_rdata             : data completion pulse and registered load word
//   m_en/m_we/m_addr/m_wdata    : registered memory controls
//   m_rdata                     : memory read data, valid the cycle after m_en is sampled
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int ADDR_W     = ADDR_W_DEF,
    parameter  int DATA_W     = DATA_W_DEF,
    parameter  int STARVE_MAX = STARVE_MAX_DEF,
    localparam int STRB_W     = DATA_W / 8,
    localparam int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [STRB_W-1:0] d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic [STRB_W-1:0] m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    state_t              state_d,   state_q;
    owner_t              owner_d,   owner_q;
    logic                wr_d,      wr_q;
    logic                m_en_d,    m_en_q;
    logic [STRB_W-1:0]   m_we_d,    m_we_q;
    logic [ADDR_W-1:0]   m_addr_d,  m_addr_q;
    logic [DATA_W-1:0]   m_wdata_d, m_wdata_q;
    logic                i_ready_d, i_ready_q;
    logic                d_ready_d, d_ready_q;
    logic [DATA_W-1:0]   i_rdata_d, i_rdata_q;
    logic [DATA_W-1:0]   d_rdata_d, d_rdata_q;
    logic                i_elig, d_elig, grant, fetch_wins;
    logic [CNT_W-1:0]    starve_cnt;

    // A port whose ready is high is finishing its access and must not be re-granted.
    assign i_elig = i_req && !i_ready_q;
    assign d_elig = d_req && !d_ready_q;
    assign grant  = (state_q == IDLE) && (i_elig || d_elig);

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_elig     (i_elig),
        .d_elig     (d_elig),
        .grant      (grant),
        .fetch_wins (fetch_wins),
        .starve_cnt (starve_cnt)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        wr_d      = wr_q;
        m_en_d    = m_en_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE: if (grant) begin
                state_d   = ISSUE;
                owner_d   = fetch_wins ? OWN_I : OWN_D;
                wr_d      = !fetch_wins && (|d_we);
                m_en_d    = 1'b1;
                m_we_d    = fetch_wins ? '0 : d_we;
                m_addr_d  = fetch_wins ? i_addr : d_addr;
                m_wdata_d = fetch_wins ? '0 : d_wdata;
            end
            ISSUE: begin
                state_d = RESP;
                m_en_d  = 1'b0;
                m_we_d  = '0;
            end
            RESP: begin
                state_d   = IDLE;
                i_ready_d = (owner_q == OWN_I);
                d_ready_d = (owner_q == OWN_D);
                i_rdata_d = (owner_q == OWN_I) ? m_rdata : i_rdata_q;
                d_rdata_d = (owner_q == OWN_D && !wr_q) ? m_rdata : d_rdata_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            wr_q      <= 1'b0;
            m_en_q    <= 1'b0;
            m_we_q    <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            m_en_q    <= m_en_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign i_ready = i_ready_q;
    assign i_rdata = i_rdata_q;
    assign d_ready = d_ready_q;
    assign d_rdata = d_rdata_q;
    assign m_en    = m_en_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a timestamp-based reference model checked every cycle
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ready;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic [SW-1:0] d_we = '0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          m_en;
    logic [SW-1:0] m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata = '0;

    int vectors = 0;
    int miscompares = 0;
    int lat;

    logic [DW-1:0] mem    [0:255];
    logic [DW-1:0] shadow [0:255];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    // Single-port synchronous memory: read-before-write, data valid next cycle.
    always @(posedge clk) begin
        if (m_en) begin
            m_rdata <= mem[m_addr[9:2]];
            for (int b = 0; b < SW; b++)
                if (m_we[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
        end
    end

    // Reference model: accesses are timestamped by the edge that grants them.
    logic          e_m_en, e_i_ready, e_d_ready;
    logic [SW-1:0] e_m_we;
    logic [AW-1:0] e_m_addr;
    logic [DW-1:0] e_m_wdata, e_i_rdata, e_d_rdata;
    int            now = 0;
    int            g_at = -100;
    logic          p_i, p_wr;
    logic [DW-1:0] p_data;
    int            starve = 0;
    string         glog = "";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %s, expected %s", name, act, exp);
        end
    endtask

    task automatic model_reset();
        e_m_en = 0; e_m_we = '0; e_m_addr = '0; e_m_wdata = '0;
        e_i_ready = 0; e_d_ready = 0; e_i_rdata = '0; e_d_rdata = '0;
        starve = 0;
        g_at = -100;
    endtask

    task automatic model_step();
        logic oi, od, ie, de, fw;
        int   idx;
        oi = e_i_ready;
        od = e_d_ready;
        e_i_ready = 0; e_d_ready = 0; e_m_en = 0; e_m_we = '0;
        if (now == g_at + 2) begin
            if (p_i) begin
                e_i_ready = 1; e_i_rdata = p_data;
            end else begin
                e_d_ready = 1;
                if (!p_wr) e_d_rdata = p_data;
            end
        end else if (now >= g_at + 3) begin
            ie = i_req && !oi;
            de = d_req && !od;
            if (ie || de) begin
                fw = ie && (!de || starve == SMAX);
                idx = fw ? int'(i_addr[9:2]) : int'(d_addr[9:2]);
                p_i = fw;
                p_wr = !fw && (d_we != 0);
                p_data = shadow[idx];
                g_at = now;
                e_m_en = 1;
                e_m_addr = fw ? i_addr : d_addr;
                e_m_we = fw ? '0 : d_we;
                e_m_wdata = fw ? '0 : d_wdata;
                if (!fw)
                    for (int b = 0; b < SW; b++)
                        if (d_we[b]) shadow[idx][8*b +: 8] = d_wdata[8*b +: 8];
                starve = (fw || !i_req) ? 0 : (starve < SMAX ? starve + 1 : SMAX);
                if (fw) glog = {glog, "I"};
                else    glog = {glog, "D"};
            end
        end
        now++;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else      model_step();
            #2;
            check("m_en",    m_en,    e_m_en);
            check("m_we",    m_we,    e_m_we);
            check("m_addr",  m_addr,  e_m_addr);
            check("m_wdata", m_wdata, e_m_wdata);
            check("i_ready", i_ready, e_i_ready);
            check("d_ready", d_ready, e_d_ready);
            check("i_rdata", i_rdata, e_i_rdata);
            check("d_rdata", d_rdata, e_d_rdata);
        end
    end

    task automatic wait_rdy(input bit dport, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dport ? d_ready : i_ready) && n < 20);
        if (!(dport ? d_ready : i_ready)) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_rdy: no ready after %0d cycles, required within 20", n);
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            mem[k] = 32'h1000_0000 + k;
            shadow[k] = mem[k];
        end
        mem[4] = 32'hDEADBEEF;
        shadow[4] = 32'hDEADBEEF;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_m_en", m_en, 0);
        check("rst_i_rdata", i_rdata, 0);
        rst = 1'b1;

        // fetch only
        i_req = 1; i_addr = 32'h10;
        @(negedge clk);
        check("f_m_en", m_en, 1);
        check("f_m_addr", m_addr, 32'h10);
        check("f_m_we", m_we, 0);
        repeat (2) @(negedge clk);
        check("f_i_ready", i_ready, 1);
        check("f_i_rdata", i_rdata, 32'hDEADBEEF);
        i_req = 0;
        @(negedge clk);
        check("f_i_ready_pulse", i_ready, 0);
        check("f_i_rdata_hold", i_rdata, 32'hDEADBEEF);

        // byte store then load
        d_req = 1; d_we = 4'b0100; d_addr = 32'h20; d_wdata = 32'h00AB0000;
        @(negedge clk);
        check("s_m_we", m_we, 4'b0100);
        check("s_m_wdata", m_wdata, 32'h00AB0000);
        repeat (2) @(negedge clk);
        check("s_d_ready", d_ready, 1);
        d_we = 4'b0000;
        wait_rdy(1, lat);
        check("l_byte", d_rdata[23:16], 8'hAB);
        check("l_word", d_rdata, 32'h10AB0008);
        d_req = 0;
        @(negedge clk);

        // simultaneous requests
        glog = "";
        i_req = 1; i_addr = 32'h10; d_req = 1; d_addr = 32'h24;
        wait_rdy(1, lat);
        check("sim_d_lat", lat, 3);
        d_req = 0;
        @(negedge clk);
        check("sim_i_en", m_en, 1);
        check("sim_i_addr", m_addr, 32'h10);
        wait_rdy(0, lat);
        i_req = 0;
        check_str("sim_order", glog, "DI");
        @(negedge clk);

        // starvation: fetch steps aside only while data is finishing
        glog = "";
        i_req = 1; d_req = 1;
        repeat (4) begin
            wait_rdy(1, lat);
            i_req = 0;
            @(negedge clk);
            i_req = 1;
        end
        check("starve_max", dut.starve_cnt, 4);
        wait_rdy(0, lat);
        i_req = 0;
        check("starve_clr", dut.starve_cnt, 0);
        check("model_starve_clr", starve, 0);
        wait_rdy(1, lat);
        d_req = 0;
        check_str("starve_order", glog, "DDDDID");
        @(negedge clk);

        // requester drops req in ISSUE
        d_req = 1; d_we = 4'hF; d_addr = 32'h28; d_wdata = 32'h12345678;
        @(negedge clk);
        d_req = 0; d_we = 0;
        repeat (2) @(negedge clk);
        check("drop_d_ready", d_ready, 1);
        repeat (3) @(negedge clk);
        check("drop_no_regrant", m_en, 0);

        // async reset in RESP
        i_req = 1; i_addr = 32'h28;
        repeat (2) @(negedge clk);
        rst = 0; i_req = 0;
        #1;
        check("rr_m_en", m_en, 0);
        check("rr_m_addr", m_addr, 0);
        check("rr_i_rdata", i_rdata, 0);
        check("rr_d_rdata", d_rdata, 0);
        repeat (2) @(negedge clk);
        check("rr_no_ready", i_ready, 0);
        rst = 1;
        i_req = 1; i_addr = 32'h28;
        wait_rdy(0, lat);
        check("post_rst_lat", lat, 3);
        check("post_rst_data", i_rdata, 32'h12345678);
        i_req = 0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
